// File: rtl/arith_result_packer.sv
// rtl/arith_result_packer.sv - buffers arithmetic results and streams each one as a byte frame
module arith_result_packer #(
    parameter int RES_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RES_WIDTH-1:0] Arith_OUT,
    input  logic                 Carry_OUT,
    input  logic                 Arith_Flag,
    output logic [7:0]           Out_Data,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic                 Out_Last,
    output logic                 Fifo_Full,
    output logic                 Fifo_Empty,
    output logic                 Overflow_Flag
);

    localparam int EW = RES_WIDTH + 1;
    localparam int NB = RES_WIDTH / 8 + 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 pop;
    logic                 push_ok;
    logic [EW-1:0]        head;

    state_t               state_q, state_n;
    logic [RES_WIDTH-1:0] shreg_q, shreg_n;
    logic [IW-1:0]        idx_q, idx_n;
    logic [7:0]           data_q, data_n;
    logic                 valid_q, valid_n;
    logic                 last_q, last_n;

    // The FSM only takes a new result while idle, which is also what frees a slot for a full-FIFO push
    assign pop     = (state_q == IDLE) && (count != '0);
    assign push_ok = Arith_Flag && ((count != CW'(FIFO_DEPTH)) || pop);
    assign head    = mem[rd_ptr];

    assign Fifo_Full     = (count == CW'(FIFO_DEPTH));
    assign Fifo_Empty    = (count == '0);
    assign Out_Data      = data_q;
    assign Out_Valid     = valid_q;
    assign Out_Last      = last_q;

    // Result FIFO storage; entries are not reset, only the pointers are
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {Carry_OUT, Arith_OUT};
        end
    end

    // FIFO pointers, occupancy and the sticky drop indicator
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            Overflow_Flag <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (Arith_Flag && !push_ok) begin
                Overflow_Flag <= 1'b1;
            end
        end
    end

    // Frame state and registered stream outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            shreg_q <= shreg_n;
            idx_q   <= idx_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            last_q  <= last_n;
        end
    end

    // Next frame state: load header on pop, shift out result bytes MSB first on each handshake
    always_comb begin
        state_n = state_q;
        shreg_n = shreg_q;
        idx_n   = idx_q;
        data_n  = data_q;
        valid_n = valid_q;
        last_n  = last_q;
        case (state_q)
            IDLE: begin
                valid_n = 1'b0;
                data_n  = '0;
                last_n  = 1'b0;
                if (pop) begin
                    state_n = SEND;
                    shreg_n = head[RES_WIDTH-1:0];
                    idx_n   = '0;
                    data_n  = {4'hA, 3'b000, head[RES_WIDTH]};
                    valid_n = 1'b1;
                    last_n  = 1'b0;
                end
            end
            SEND: begin
                if (Out_Ready) begin
                    if (idx_q == IW'(NB - 1)) begin
                        // Returning to IDLE forces the mandatory one-cycle gap between frames
                        state_n = IDLE;
                        valid_n = 1'b0;
                        data_n  = '0;
                        last_n  = 1'b0;
                    end else begin
                        idx_n   = idx_q + IW'(1);
                        data_n  = shreg_q[RES_WIDTH-1 -: 8];
                        shreg_n = shreg_q << 8;
                        last_n  = (idx_q == IW'(NB - 2));
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                data_n  = '0;
                last_n  = 1'b0;
            end
        endcase
    end

endmodule
